// File: rtl/operand_stream_pkg.sv
// Shared types for the operand stream transmitter.
package operand_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/operand_stream_tx_if.sv
// Host SRAM read port plus the valid/ready operand stream towards the chip.
interface operand_stream_tx_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20
) ();
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_qout;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    output mem_re, mem_addr, data_out, data_valid,
    input  mem_qout, data_ready
  );

  modport slave (
    input  mem_re, mem_addr, data_out, data_valid,
    output mem_qout, data_ready
  );
endinterface

// File: rtl/stream_fifo.sv
// Small registered synchronous FIFO; head is read straight from flops so the
// output never sees a combinational path from the write data.
module stream_fifo #(
  parameter  int DATA_WIDTH = 16,
  parameter  int FIFO_DEPTH = 2,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
  localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it holding its old value (no latch).
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      // NOTE: storage is reset on purpose: the head drives data_out, which must read 0 out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/operand_stream_tx.sv
// Reads LENGTH words from host SRAM starting at BASE and streams them out,
// prefetching only as far as the FIFO has room for words already in flight.
module operand_stream_tx
  import operand_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20,
  parameter int LEN_WIDTH  = 21,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  operand_stream_tx_if.master   bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = CNT_W + 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  sent_q, sent_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;

  logic                  fifo_full, fifo_empty, pop, mem_re, credit_ok;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;

  stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .push      (inflight_q),
    .push_data (bus.mem_qout),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign pop = !fifo_empty && bus.data_ready;
  // A slot freed by this cycle's pop may be reused by this cycle's read.
  assign credit_ok = (CRD_W'(fifo_count) + CRD_W'(inflight_q)) < (CRD_W'(FIFO_DEPTH) + CRD_W'(pop));
  assign mem_re    = (state_q == FETCH) && credit_ok;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q + LEN_WIDTH'(mem_re);
    sent_d     = sent_q + LEN_WIDTH'(pop);
    inflight_d = mem_re;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (length != '0)) begin
          state_d  = FETCH;
          base_d   = base_addr;
          len_d    = length;
          issued_d = '0;
          sent_d   = '0;
        end else if (start) begin
          done_d = 1'b1;
        end
      end
      FETCH: begin
        if (mem_re && (issued_q + LEN_WIDTH'(1) == len_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (sent_q + LEN_WIDTH'(1) == len_q)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign bus.mem_re     = mem_re;
  assign bus.mem_addr   = base_q + issued_q[ADDR_WIDTH-1:0];
  assign bus.data_valid = !fifo_empty;
  assign bus.data_out   = fifo_head;

  overflow_a: assert property (@(posedge clk) disable iff (!arst_n_in)
    !(inflight_q && fifo_full && !pop))
    else $error("operand_stream_tx: prefetch FIFO overflow");

endmodule

// File: tb/tb_operand_stream_tx.sv
// Directed bench for operand_stream_tx with a 1-cycle-latency SRAM model.
module tb_operand_stream_tx;

  logic        clk = 1'b0;
  logic        arst_n_in;
  logic        start;
  logic [19:0] base_addr;
  logic [20:0] length;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  operand_stream_tx_if #(.DATA_WIDTH(16), .ADDR_WIDTH(20)) bus ();

  operand_stream_tx #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (20),
    .LEN_WIDTH  (21),
    .FIFO_DEPTH (2)
  ) dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] data_of(input logic [19:0] a);
    return a[15:0] ^ {a[19:16], 12'h5C3};
  endfunction

  // SRAM with fixed 1-cycle read latency
  always @(posedge clk) if (bus.mem_re) bus.mem_qout <= data_of(bus.mem_addr);

  // Event logs, sampled on the falling edge
  logic [19:0] addr_q[$];
  int          addr_cyc[$];
  logic [15:0] rx_q[$];
  int          rx_cyc[$];
  int          done_cyc[$];
  int          busy_cnt, stab_err, occ_err, reads, pops;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    if (!arst_n_in) begin
      reads = 0;
      pops = 0;
      prev_stall = 1'b0;
    end else begin
      if (reads - pops > 2) occ_err++;
      if (prev_stall && !(bus.data_valid && bus.data_out == prev_data)) stab_err++;
      if (bus.mem_re) begin
        addr_q.push_back(bus.mem_addr);
        addr_cyc.push_back(cyc);
        reads++;
      end
      if (bus.data_valid && bus.data_ready) begin
        rx_q.push_back(bus.data_out);
        rx_cyc.push_back(cyc);
        pops++;
      end
      if (done) done_cyc.push_back(cyc);
      if (busy) busy_cnt++;
      prev_stall = bus.data_valid && !bus.data_ready;
      prev_data  = bus.data_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_q.delete(); addr_cyc.delete(); rx_q.delete(); rx_cyc.delete(); done_cyc.delete();
    busy_cnt = 0; stab_err = 0; occ_err = 0;
  endtask

  // Returns the edge count at which start was sampled.
  task automatic do_start(input logic [19:0] b, input logic [20:0] l, output int t0);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    tick();
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget && done_cyc.size() == 0; n++) tick();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    arst_n_in = 1'b0; start = 1'b0; base_addr = '0; length = '0; bus.data_ready = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({busy, done, bus.mem_re, bus.data_valid} !== 4'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, bus.mem_re, bus.data_valid});
    end
    arst_n_in = 1'b1;
    clear_logs();
    repeat (10) tick();
    vectors++;
    if ({busy, done, bus.mem_re, bus.data_valid} !== 4'b0) begin
      miscompares++; $display("FAIL idle_ctrl: got %b want 0000", {busy, done, bus.mem_re, bus.data_valid});
    end
    vectors++;
    if (bus.mem_addr !== 20'h0) begin miscompares++; $display("FAIL idle_addr: got %h want 0", bus.mem_addr); end
    vectors++;
    if (bus.data_out !== 16'h0) begin miscompares++; $display("FAIL idle_data: got %h want 0", bus.data_out); end
    vectors++;
    if (addr_q.size() + done_cyc.size() + busy_cnt != 0) begin
      miscompares++; $display("FAIL idle_activity: got %0d reads %0d dones %0d busy want none", addr_q.size(), done_cyc.size(), busy_cnt);
    end
  endtask

  task automatic test_basic();
    int t0;
    bus.data_ready = 1'b1;
    clear_logs();
    do_start(20'h10, 21'd4, t0);
    wait_done(40);
    vectors++;
    if (addr_q.size() != 4) begin miscompares++; $display("FAIL basic_nreads: got %0d want 4", addr_q.size()); end
    for (int i = 0; i < addr_q.size() && i < 4; i++) begin
      vectors++;
      if (addr_q[i] !== 20'h10 + 20'(i) || addr_cyc[i] != t0 + i) begin
        miscompares++; $display("FAIL basic_addr[%0d]: got %h@%0d want %h@%0d", i, addr_q[i], addr_cyc[i], 20'h10 + 20'(i), t0 + i);
      end
    end
    vectors++;
    if (rx_q.size() != 4) begin miscompares++; $display("FAIL basic_nwords: got %0d want 4", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 4; i++) begin
      vectors++;
      if (rx_q[i] !== data_of(20'h10 + 20'(i)) || rx_cyc[i] != t0 + 2 + i) begin
        miscompares++; $display("FAIL basic_word[%0d]: got %h@%0d want %h@%0d", i, rx_q[i], rx_cyc[i], data_of(20'h10 + 20'(i)), t0 + 2 + i);
      end
    end
    vectors++;
    if (done_cyc.size() != 1 || done_cyc[0] != t0 + 6) begin
      miscompares++; $display("FAIL basic_done: got %0d pulses first@%0d want 1@%0d", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t0 + 6);
    end
    vectors++;
    if (busy_cnt != 6) begin miscompares++; $display("FAIL basic_busy: got %0d cycles want 6", busy_cnt); end
  endtask

  task automatic test_backpressure();
    int t0;
    logic [15:0] pat = 16'b0110_1100_1010_1001; // bit0 first: 1,0,0,1,0,1,0,1,...
    clear_logs();
    bus.data_ready = pat[0];
    do_start(20'h100, 21'd8, t0);
    for (int i = 1; i < 300 && done_cyc.size() == 0; i++) begin
      bus.data_ready = pat[i % 16];
      tick();
    end
    bus.data_ready = 1'b1;
    repeat (3) tick();
    vectors++;
    if (rx_q.size() != 8) begin miscompares++; $display("FAIL bp_nwords: got %0d want 8", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 8; i++) begin
      vectors++;
      if (rx_q[i] !== data_of(20'h100 + 20'(i))) begin
        miscompares++; $display("FAIL bp_word[%0d]: got %h want %h", i, rx_q[i], data_of(20'h100 + 20'(i)));
      end
    end
    vectors++;
    if (stab_err != 0) begin miscompares++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_err); end
    vectors++;
    if (occ_err != 0) begin miscompares++; $display("FAIL bp_occupancy: got %0d cycles above 2 want 0", occ_err); end
    vectors++;
    if (done_cyc.size() != 1) begin miscompares++; $display("FAIL bp_done: got %0d pulses want 1", done_cyc.size()); end
  endtask

  task automatic test_wrap();
    int t0;
    logic [19:0] exp_a [4] = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
    bus.data_ready = 1'b1;
    clear_logs();
    do_start(20'hFFFFE, 21'd4, t0);
    wait_done(40);
    vectors++;
    if (addr_q.size() != 4 || rx_q.size() != 4) begin
      miscompares++; $display("FAIL wrap_count: got %0d reads %0d words want 4 4", addr_q.size(), rx_q.size());
    end
    for (int i = 0; i < addr_q.size() && i < rx_q.size() && i < 4; i++) begin
      vectors++;
      if (addr_q[i] !== exp_a[i] || rx_q[i] !== data_of(exp_a[i])) begin
        miscompares++; $display("FAIL wrap[%0d]: got %h/%h want %h/%h", i, addr_q[i], rx_q[i], exp_a[i], data_of(exp_a[i]));
      end
    end
  endtask

  task automatic test_zero_len_and_busy_start();
    int t0;
    bus.data_ready = 1'b1;
    clear_logs();
    do_start(20'h500, 21'd0, t0);
    repeat (5) tick();
    vectors++;
    if (done_cyc.size() != 1 || done_cyc[0] != t0) begin
      miscompares++; $display("FAIL zlen_done: got %0d pulses first@%0d want 1@%0d", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t0);
    end
    vectors++;
    if (busy_cnt != 0 || addr_q.size() != 0) begin
      miscompares++; $display("FAIL zlen_idle: got busy %0d reads %0d want 0 0", busy_cnt, addr_q.size());
    end
    clear_logs();
    do_start(20'h200, 21'd4, t0);
    tick();
    base_addr = 20'h300; length = 21'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40);
    repeat (5) tick();
    vectors++;
    if (addr_q.size() != 4 || rx_q.size() != 4 || done_cyc.size() != 1) begin
      miscompares++; $display("FAIL busy_start_count: got %0d reads %0d words %0d dones want 4 4 1", addr_q.size(), rx_q.size(), done_cyc.size());
    end
    for (int i = 0; i < rx_q.size() && i < 4; i++) begin
      vectors++;
      if (rx_q[i] !== data_of(20'h200 + 20'(i))) begin
        miscompares++; $display("FAIL busy_start_word[%0d]: got %h want %h", i, rx_q[i], data_of(20'h200 + 20'(i)));
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    bus.data_ready = 1'b1;
    clear_logs();
    do_start(20'h80, 21'd6, t0);
    for (int n = 0; n < 40 && rx_q.size() < 3; n++) tick();
    arst_n_in = 1'b0;
    #1;
    vectors++;
    if ({busy, done, bus.mem_re, bus.data_valid} !== 4'b0 || bus.mem_addr !== 20'h0 || bus.data_out !== 16'h0) begin
      miscompares++; $display("FAIL midrst_outputs: got ctrl %b addr %h data %h want 0", {busy, done, bus.mem_re, bus.data_valid}, bus.mem_addr, bus.data_out);
    end
    repeat (2) tick();
    arst_n_in = 1'b1;
    repeat (8) tick();
    vectors++;
    if (rx_q.size() != 3 || done_cyc.size() != 0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL midrst_abandon: got %0d words %0d dones busy %b want 3 0 0", rx_q.size(), done_cyc.size(), busy);
    end
    clear_logs();
    do_start(20'h40, 21'd2, t0);
    wait_done(40);
    vectors++;
    if (rx_q.size() != 2 || done_cyc.size() != 1) begin
      miscompares++; $display("FAIL restart_count: got %0d words %0d dones want 2 1", rx_q.size(), done_cyc.size());
    end
    for (int i = 0; i < rx_q.size() && i < 2; i++) begin
      vectors++;
      if (rx_q[i] !== data_of(20'h40 + 20'(i))) begin
        miscompares++; $display("FAIL restart_word[%0d]: got %h want %h", i, rx_q[i], data_of(20'h40 + 20'(i)));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len_and_busy_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
